// File: rtl/axis_icrc_insert.sv
// axis_icrc_insert: RoCEv2 ICRC over the masked stream, appended to the unmasked frame.
// Define ICRC_DUMMY_LRH_EN to fold the 8-byte 0xFF dummy-LRH prefix into the seed.
module axis_icrc_insert #(
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   s_axis_masked_tdata,
   input  logic [DATA_WIDTH-1:0]   s_axis_not_masked_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [USER_WIDTH-1:0]   s_axis_tuser,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [USER_WIDTH-1:0]   m_axis_tuser
);
   localparam int B = DATA_WIDTH/8;
   localparam int NW = $clog2(B+1);

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
      return r;
   endfunction

`ifdef ICRC_DUMMY_LRH_EN
   function automatic logic [31:0] lrh_seed(input logic [31:0] c);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = crc_byte(r, 8'hFF);
      return r;
   endfunction
   localparam logic [31:0] SEED = lrh_seed(32'hFFFFFFFF);
`else
   localparam logic [31:0] SEED = 32'hFFFFFFFF;
`endif

   typedef enum logic {PASS, EXTRA} state_t;
   state_t state;
   logic [31:0] crc_reg, crc_next;
   logic [NW-1:0] n;
   logic [DATA_WIDTH-1:0] keep_mask, extra_reg;
   logic [B-1:0] extra_keep;
   logic [2*DATA_WIDTH-1:0] wide;
   logic [2*B-1:0] wkeep;
   logic s_fire;

   // the ICRC is shifted in right after the last valid byte; anything past B lanes overflows
   always_comb begin
      crc_next = crc_reg;
      n = '0;
      keep_mask = '0;
      for (int i = 0; i < B; i++)
         if (s_axis_tkeep[i]) begin
            crc_next = crc_byte(crc_next, s_axis_masked_tdata[8*i +: 8]);
            n = n + 1'b1;
            keep_mask[8*i +: 8] = 8'hFF;
         end
      wide = {{DATA_WIDTH{1'b0}}, s_axis_not_masked_tdata & keep_mask} |
             ({{(2*DATA_WIDTH-32){1'b0}}, ~crc_next} << {n, 3'b000});
      wkeep = ({{(2*B-4){1'b0}}, 4'hF} << n) | {{B{1'b0}}, s_axis_tkeep};
   end

   assign s_axis_tready = !rst && state == PASS && (!m_axis_tvalid || m_axis_tready);
   assign s_fire = s_axis_tvalid && s_axis_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= PASS;
         crc_reg <= SEED;
         extra_reg <= '0;
         extra_keep <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tkeep <= '0;
         m_axis_tlast <= 1'b0;
         m_axis_tuser <= '0;
      end else if (state == PASS) begin
         if (s_fire) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= s_axis_tlast ? wide[DATA_WIDTH-1:0] : s_axis_not_masked_tdata & keep_mask;
            m_axis_tkeep <= s_axis_tlast ? wkeep[B-1:0] : s_axis_tkeep;
            m_axis_tlast <= s_axis_tlast && !wkeep[B];
            m_axis_tuser <= s_axis_tuser;
            crc_reg <= s_axis_tlast ? SEED : crc_next;
            if (s_axis_tlast && wkeep[B]) begin
               state <= EXTRA;
               extra_reg <= wide[2*DATA_WIDTH-1:DATA_WIDTH];
               extra_keep <= wkeep[2*B-1:B];
            end
         end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      end else if (m_axis_tready) begin
         // first the truncated last beat drains, then the overflow beat keeps its tuser
         if (m_axis_tlast) begin
            m_axis_tvalid <= 1'b0;
            state <= PASS;
         end else begin
            m_axis_tdata <= extra_reg;
            m_axis_tkeep <= extra_keep;
            m_axis_tlast <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_axis_icrc_insert.sv
// tb_axis_icrc_insert: directed and randomized frames checked against a byte-stream CRC model.
module tb_axis_icrc_insert;
   typedef struct packed {logic [63:0] d; logic [7:0] k; logic l; logic u;} beat_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [63:0] s_axis_masked_tdata = '0, s_axis_not_masked_tdata = '0;
   logic [7:0] s_axis_tkeep = '0;
   logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
   logic [0:0] s_axis_tuser = '0;
   logic [63:0] m_axis_tdata;
   logic [7:0] m_axis_tkeep;
   logic m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
   logic [0:0] m_axis_tuser;
   logic bp_rand = 1'b0, tr_force = 1'b1, gaps = 1'b0;
   int checks = 0, passes = 0, fails = 0;
   beat_t exp_q[$];

   axis_icrc_insert #(.DATA_WIDTH(64), .USER_WIDTH(1)) dut (
      .clk(clk), .rst(rst),
      .s_axis_masked_tdata(s_axis_masked_tdata), .s_axis_not_masked_tdata(s_axis_not_masked_tdata),
      .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      m_axis_tready = bp_rand ? ($urandom_range(0, 2) != 0) : tr_force;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_icrc(input logic [7:0] b[$]);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         c ^= {24'd0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
      end
      return ~c;
   endfunction

   // output stream = unmasked bytes followed by the ICRC little-endian, cut into 8-byte beats
   task automatic expect_frame(input logic [7:0] ub[$], input logic [31:0] icrc, input logic u[$]);
      logic [7:0] o[$];
      beat_t e;
      int nout, nin;
      o = ub;
      for (int k = 0; k < 4; k++) o.push_back(icrc[8*k +: 8]);
      nout = (o.size() + 7) / 8;
      nin = ub.size() == 0 ? 1 : (ub.size() + 7) / 8;
      for (int j = 0; j < nout; j++) begin
         e = '0;
         for (int i = 0; i < 8; i++)
            if (j*8 + i < o.size()) begin
               e.d[8*i +: 8] = o[j*8 + i];
               e.k[i] = 1'b1;
            end
         e.l = (j == nout - 1);
         e.u = u[j < nin ? j : nin - 1];
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_beat(input logic [63:0] md, input logic [63:0] ud, input logic [7:0] k,
                             input logic l, input logic u);
      logic fire;
      int n = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
         @(posedge clk);
         #1;
      end
      s_axis_masked_tdata = md;
      s_axis_not_masked_tdata = ud;
      s_axis_tkeep = k;
      s_axis_tlast = l;
      s_axis_tuser = u;
      s_axis_tvalid = 1'b1;
      do begin
         @(negedge clk);
         fire = s_axis_tready;
         @(posedge clk);
         #1;
         n++;
      end while (!fire && n < 1000);
      if (!fire) chk("accept timeout", 0, 1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] mb[$], input logic [7:0] ub[$], input logic u[$]);
      int nb;
      logic [63:0] md, ud;
      logic [7:0] k;
      nb = mb.size() == 0 ? 1 : (mb.size() + 7) / 8;
      for (int j = 0; j < nb; j++) begin
         md = {$urandom, $urandom};
         ud = {$urandom, $urandom};
         k = '0;
         for (int i = 0; i < 8; i++)
            if (j*8 + i < mb.size()) begin
               md[8*i +: 8] = mb[j*8 + i];
               ud[8*i +: 8] = ub[j*8 + i];
               k[i] = 1'b1;
            end
         drive_beat(md, ud, k, j == nb - 1, u[j]);
      end
   endtask

   task automatic rand_frame(input int len);
      logic [7:0] mb[$], ub[$];
      logic u[$];
      for (int i = 0; i < len; i++) begin
         mb.push_back(8'($urandom));
         ub.push_back(8'($urandom));
      end
      for (int j = 0; j < 6; j++) u.push_back(1'($urandom));
      expect_frame(ub, ref_icrc(mb), u);
      send_frame(mb, ub, u);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("drain", 128'(exp_q.size()), 0);
   endtask

   beat_t prev, e;
   logic stalled = 1'b0;
   always @(negedge clk) begin
      if (rst) stalled = 1'b0;
      else if (m_axis_tvalid) begin
         if (stalled) chk("stable", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, prev);
         if (m_axis_tready) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) chk("unexpected beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("tdata", m_axis_tdata, e.d);
               chk("tkeep", m_axis_tkeep, e.k);
               chk("tlast", m_axis_tlast, e.l);
               chk("tuser", m_axis_tuser, e.u);
            end
         end else begin
            stalled = 1'b1;
            prev = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
         end
      end else if (stalled) chk("valid dropped while stalled", 0, 1);
   end

   logic [7:0] q9[$], qa[$], qr[$];
   logic u2[$];
   initial begin
      #1;
      chk("reset tvalid", m_axis_tvalid, 0);
      chk("reset tdata", m_axis_tdata, 0);
      chk("reset tready", s_axis_tready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("tready after reset", s_axis_tready, 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) begin
         q9.push_back(8'h31 + 8'(i));
         qa.push_back(8'hAA);
      end
      u2 = '{1'b0, 1'b0};
      // "123456789" -> ICRC 0xCBF43926 in lanes 1..4 of the second beat
      exp_q.push_back('{d: 64'h3837363534333231, k: 8'hFF, l: 1'b0, u: 1'b0});
      exp_q.push_back('{d: 64'h000000CBF4392639, k: 8'h1F, l: 1'b1, u: 1'b0});
      send_frame(q9, q9, u2);
      exp_q.push_back('{d: 64'hAAAAAAAAAAAAAAAA, k: 8'hFF, l: 1'b0, u: 1'b0});
      exp_q.push_back('{d: 64'h000000CBF43926AA, k: 8'h1F, l: 1'b1, u: 1'b0});
      send_frame(q9, qa, u2);
      drain();
      for (int i = 0; i < 8; i++) qr.push_back(8'($urandom));
      u2 = '{1'b1, 1'b1};
      expect_frame(qr, ref_icrc(qr), u2);
      send_frame(qr, qr, u2);
      @(negedge clk);
      chk("tready during extra", s_axis_tready, 0);
      @(posedge clk);
      #1;
      drain();
      rand_frame(13);
      rand_frame(0);
      rand_frame(4);
      rand_frame(5);
      drain();
      bp_rand = 1'b1;
      gaps = 1'b1;
      for (int f = 0; f < 100; f++) rand_frame($urandom_range(0, 40));
      drain();
      bp_rand = 1'b0;
      gaps = 1'b0;
      tr_force = 1'b0;
      @(posedge clk);
      #1;
      drive_beat({$urandom, $urandom}, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid reset tvalid", m_axis_tvalid, 0);
      chk("mid reset tdata", m_axis_tdata, 0);
      chk("mid reset tkeep", m_axis_tkeep, 0);
      chk("mid reset tready", s_axis_tready, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tr_force = 1'b1;
      @(posedge clk);
      #1;
      u2 = '{1'b0, 1'b1};
      exp_q.push_back('{d: 64'h3837363534333231, k: 8'hFF, l: 1'b0, u: 1'b0});
      exp_q.push_back('{d: 64'h000000CBF4392639, k: 8'h1F, l: 1'b1, u: 1'b1});
      send_frame(q9, q9, u2);
      drain();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/axis_icrc_insert.md
# axis_icrc_insert

Computes the RoCEv2 invariant CRC (ICRC) over the masked stream produced by the ICRC field-masking stage, then appends the 4-byte ICRC to the matching unmasked frame. It sits directly downstream of the masking stage on the TX path, between the masker and the MAC-side AXI-stream FIFO. CRC input is the masked data. Output data is the unmasked data with the ICRC inserted after the last valid byte; this adds one extra beat when the last beat lacks room.

## Interface
- DATA_WIDTH, 64, stream width in bits; multiple of 32, 64..512.
- USER_WIDTH, 1, sideband passed through unchanged.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- s_axis_masked_tdata  input  DATA_WIDTH  masked data; CRC input only.
- s_axis_not_masked_tdata  input  DATA_WIDTH  original data; forwarded to output.
- s_axis_tkeep  input  DATA_WIDTH/8  byte enables; contiguous and LSB-aligned.
- s_axis_tvalid / s_axis_tready  input / output  1  handshake; shared by both data buses.
- s_axis_tlast  input  1  end of frame.
- s_axis_tuser  input  USER_WIDTH  sideband.
- m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tready (input), m_axis_tlast, m_axis_tuser  output  matching widths  frame with ICRC appended.

## Operation
- CRC-32: polynomial 0x04C11DB7, reflected (LSB-first per byte), seed 0xFFFFFFFF, final value bit-inverted. Only bytes with tkeep=1 are processed.
- crc_reg holds the running state. It updates on every accepted beat and returns to the seed after an accepted tlast beat.
- On an accepted beat, the output register loads the unmasked data, tkeep, tlast and tuser.
- On an accepted tlast beat with N valid bytes (B = DATA_WIDTH/8):
  - ICRC = ~crc_next.
  - ICRC bytes are placed little-endian (ICRC[7:0] first) at lanes N..N+3.
  - If N+4 <= B: tkeep becomes (1<<(N+4))-1 and tlast stays 1.
  - Otherwise: the first B-N ICRC bytes fill the current beat, and tlast is cleared.
  - The remaining N+4-B bytes are held in extra_reg and the FSM enters EXTRA.
- FSM states:
  - PASS: normal operation.
  - EXTRA: the output holds the overflow beat, with bytes at lanes 0..N+3-B, tkeep=(1<<(N+4-B))-1, tlast=1, and tuser equal to the last input beat's tuser.
  - EXTRA -> PASS when that beat handshakes.
- tkeep=0 with tlast: N=0, so the ICRC occupies lanes 0..3 of that beat.
- Unused output byte lanes are driven 0.
- Non-contiguous tkeep is undefined behaviour; no detection.
- If ICRC_DUMMY_LRH_EN is defined, the per-frame seed is the CRC state after processing 8 bytes of 0xFF from 0xFFFFFFFF. This constant is computed at elaboration with the same CRC function.

## Timing
- Latency: 1 cycle from input accept to m_axis_tvalid.
- s_axis_tready = (state==PASS) && (!m_axis_tvalid || m_axis_tready). This is a combinational path from m_axis_tready.
- Full throughput except one bubble per frame that needs an EXTRA beat.
- The output register holds all m_axis signals stable while tvalid=1 and tready=0.
- Back-to-back frames: a new frame's first beat may be accepted in the same cycle the previous tlast beat leaves the output, when the FSM is in PASS. The CRC seed is already restored at that point.
- Reset values, asynchronous and immediate:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tuser=0.
  - state=PASS, crc_reg=seed, extra_reg=0.
  - s_axis_tready=0 while rst is high, then 1 on the first cycle after release.
- Reset mid-frame: the partial frame is discarded and no ICRC is emitted. The next accepted beat starts a new frame.

## Configuration
- ICRC_DUMMY_LRH_EN:
  - Defined: the seed includes the RoCEv2 8-byte 0xFF dummy-LRH prefix, matching the ICRC of native-IB-equivalent packets.
  - Undefined: the seed is 0xFFFFFFFF, a plain CRC-32 over the masked bytes.

## Test plan
- Macro off. Masked data "123456789" (bytes 0x31..0x39): beat0 tkeep 0xFF, beat1 tkeep 0x01 tlast. Required output: beat1 tkeep 0x1F, lanes 1..4 = 0x26,0x39,0xF4,0xCB, tlast=1, and no extra beat.
- Same masked data but unmasked data all 0xAA. Required output: data lanes are 0xAA with the same ICRC 0xCBF43926, proving the CRC uses masked data and the output uses unmasked data.
- 8-byte frame with tkeep 0xFF tlast. Required: beat0 unchanged with tlast=0, then an extra beat with tkeep 0x0F and tlast=1. s_axis_tready is 0 during the EXTRA cycle.
- 13-byte frame (last beat tkeep 0x1F). Required: last beat tkeep 0xFF carrying 3 ICRC bytes, then an extra beat with tkeep 0x01 carrying ICRC[31:24].
- Random m_axis_tready backpressure over 100 back-to-back frames. Required: no beat loss or duplication, outputs stable while stalled, and every ICRC matches the reference model.
- Assert rst mid-frame, then send "123456789". Required: outputs go to 0 immediately, and the post-reset frame carries ICRC 0xCBF43926.
